// File: rtl/sha_sched_pkg.sv
// Shared types and limits for the SHA-256 nonce scheduler and its arbiter.
package sha_sched_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} sched_state_t;

  localparam int MAX_CORES = 16;
  localparam int TAG_W     = 16;

  typedef logic [TAG_W-1:0] tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, search starts one past the last grant.
// The pointer is a one-hot copy of the last grant and resets to index 0.
module rr_arbiter import sha_sched_pkg::*; #(
  parameter int WIDTH = MAX_CORES
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] req,
  output logic [WIDTH-1:0] grant
);

  logic [WIDTH-1:0] last_oh;
  logic [WIDTH-1:0] above_mask;
  logic [WIDTH-1:0] req_hi;

  // Requests strictly above the last grant win first; otherwise wrap to the lowest.
  always_comb begin
    above_mask = ~((last_oh << 1) - WIDTH'(1));
    req_hi     = req & above_mask;
    if (|req_hi) begin
      grant = req_hi & (~req_hi + WIDTH'(1));
    end else begin
      grant = req & (~req + WIDTH'(1));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_oh <= WIDTH'(1);
    end else if (|grant) begin
      last_oh <= grant;
    end
  end

endmodule

// File: rtl/nonce_scheduler.sv
// Dispatches nonces to NUM_CORES hash cores and serialises their h0 results to one write port.
// Optional NONCE_SCHED_CYCLES_EN adds a start-to-idle cycle counter output.
module nonce_scheduler #(
  parameter int NUM_CORES     = 4,
  parameter int NUM_OF_NONCES = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [15:0]            output_addr,
  output logic                   done,
  output logic [NUM_CORES-1:0]   core_start,
  output logic [31:0]            core_nonce,
  input  logic [NUM_CORES-1:0]   core_done,
  input  logic [32*NUM_CORES-1:0] core_h0,
  output logic [NUM_CORES-1:0]   core_ack,
  output logic                   mem_clk,
  output logic                   mem_we,
  output logic [15:0]            mem_addr,
  output logic [31:0]            mem_write_data
`ifdef NONCE_SCHED_CYCLES_EN
  ,
  output logic [31:0]            cycle_count
`endif
);
  import sha_sched_pkg::*;

  localparam tag_t LAST_NONCE = tag_t'(NUM_OF_NONCES);

  sched_state_t         state, state_nxt;
  tag_t                 next_nonce;
  tag_t                 base_addr;
  tag_t                 tag [NUM_CORES];
  logic [NUM_CORES-1:0] busy;
  logic [NUM_CORES-1:0] elig;
  logic [NUM_CORES-1:0] disp;
  logic [NUM_CORES-1:0] wb_req;
  logic [NUM_CORES-1:0] wb_grant;
  tag_t                 wb_tag;
  logic [31:0]          wb_data;

  assign mem_clk = clk;
  assign done    = (state == IDLE);

  always_comb begin
    state_nxt = state;
    elig      = ~busy & ~core_ack;
    disp      = '0;
    wb_req    = '0;
    case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        if (next_nonce == LAST_NONCE) begin
          state_nxt = DRAIN;
        end else begin
          disp = elig & (~elig + NUM_CORES'(1));
        end
        wb_req = core_done & busy & ~core_ack;
      end
      DRAIN: begin
        wb_req = core_done & busy & ~core_ack;
        if (busy == '0 && core_ack == '0) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  rr_arbiter #(.WIDTH(NUM_CORES)) u_wb_arb (
    .clk    (clk),
    .reset_n(reset_n),
    .req    (wb_req),
    .grant  (wb_grant)
  );

  always_comb begin
    wb_tag  = '0;
    wb_data = '0;
    for (int c = 0; c < NUM_CORES; c++) begin
      if (wb_grant[c]) begin
        wb_tag  = tag[c];
        wb_data = core_h0[32*c +: 32];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      next_nonce     <= '0;
      base_addr      <= '0;
      busy           <= '0;
      core_start     <= '0;
      core_nonce     <= '0;
      core_ack       <= '0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_write_data <= '0;
      for (int c = 0; c < NUM_CORES; c++) tag[c] <= '0;
    end else begin
      core_start <= disp;
      core_ack   <= wb_grant;
      mem_we     <= |wb_grant;
      // Dispatch and writeback never target the same core: one needs busy low, the other high.
      busy       <= (busy | disp) & ~wb_grant;
      if (state == IDLE && start) begin
        base_addr  <= output_addr;
        next_nonce <= '0;
      end
      if (|disp) begin
        core_nonce <= 32'(next_nonce);
        next_nonce <= next_nonce + 1'b1;
      end
      for (int c = 0; c < NUM_CORES; c++) begin
        if (disp[c]) tag[c] <= next_nonce;
      end
      if (|wb_grant) begin
        mem_addr       <= base_addr + wb_tag;
        mem_write_data <= wb_data;
      end
    end
  end

`ifdef NONCE_SCHED_CYCLES_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cycle_count <= '0;
    end else if (state == IDLE) begin
      if (start) cycle_count <= '0;
    end else begin
      cycle_count <= cycle_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_nonce_scheduler.sv
// Directed bench: two scheduler instances (16 nonces and 4 nonces) driving behavioural hash cores.
module tb_nonce_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;

  logic        a_start, a_done, a_mem_clk, a_mem_we;
  logic [15:0] a_output_addr, a_mem_addr;
  logic [3:0]  a_core_start, a_core_done, a_core_ack;
  logic [31:0] a_core_nonce, a_mem_write_data;
  logic [127:0] a_core_h0;

  logic        b_start, b_done, b_mem_clk, b_mem_we;
  logic [15:0] b_output_addr, b_mem_addr;
  logic [3:0]  b_core_start, b_core_done, b_core_ack;
  logic [31:0] b_core_nonce, b_mem_write_data;
  logic [127:0] b_core_h0;

`ifdef NONCE_SCHED_CYCLES_EN
  logic [31:0] a_cycle_count, b_cycle_count;
`endif

  nonce_scheduler #(.NUM_CORES(4), .NUM_OF_NONCES(16)) u_dut (
`ifdef NONCE_SCHED_CYCLES_EN
    .cycle_count   (a_cycle_count),
`endif
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (a_start),
    .output_addr   (a_output_addr),
    .done          (a_done),
    .core_start    (a_core_start),
    .core_nonce    (a_core_nonce),
    .core_done     (a_core_done),
    .core_h0       (a_core_h0),
    .core_ack      (a_core_ack),
    .mem_clk       (a_mem_clk),
    .mem_we        (a_mem_we),
    .mem_addr      (a_mem_addr),
    .mem_write_data(a_mem_write_data)
  );

  nonce_scheduler #(.NUM_CORES(4), .NUM_OF_NONCES(4)) u_dut_wrap (
`ifdef NONCE_SCHED_CYCLES_EN
    .cycle_count   (b_cycle_count),
`endif
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (b_start),
    .output_addr   (b_output_addr),
    .done          (b_done),
    .core_start    (b_core_start),
    .core_nonce    (b_core_nonce),
    .core_done     (b_core_done),
    .core_h0       (b_core_h0),
    .core_ack      (b_core_ack),
    .mem_clk       (b_mem_clk),
    .mem_we        (b_mem_we),
    .mem_addr      (b_mem_addr),
    .mem_write_data(b_mem_write_data)
  );

  // Behavioural cores: indices 0..3 serve u_dut, 4..7 serve u_dut_wrap.
  logic [7:0]   cs_all, ack_all, done_all, hold;
  logic [255:0] h0_all;

  assign cs_all      = {b_core_start, a_core_start};
  assign ack_all     = {b_core_ack, a_core_ack};
  assign a_core_done = done_all[3:0];
  assign b_core_done = done_all[7:4];
  assign a_core_h0   = h0_all[127:0];
  assign b_core_h0   = h0_all[255:128];

  for (genvar k = 0; k < 8; k++) begin : g_core
    int          cnt;
    logic        dint;
    logic [31:0] nn;
    always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt  <= 0;
        dint <= 1'b0;
        nn   <= '0;
      end else begin
        if (ack_all[k]) dint <= 1'b0;
        else if (cnt == 1) dint <= 1'b1;
        if (cnt > 0) cnt <= cnt - 1;
        if (cs_all[k]) begin
          cnt <= 10;
          nn  <= (k < 4) ? a_core_nonce : b_core_nonce;
        end
      end
    end
    assign done_all[k]        = dint & ~hold[k];
    assign h0_all[32*k +: 32] = 32'hA5A50000 | nn;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] wa_addr[$], wb_addr[$], da_nonce[$];
  logic [31:0] wa_data[$], wb_data[$];
  int          last_we_cyc = 0;

  always @(negedge clk) begin
    if (a_mem_we) begin
      wa_addr.push_back(a_mem_addr);
      wa_data.push_back(a_mem_write_data);
      last_we_cyc = cyc;
    end
    if (a_core_start != 4'b0) da_nonce.push_back(a_core_nonce[15:0]);
    if (b_mem_we) begin
      wb_addr.push_back(b_mem_addr);
      wb_data.push_back(b_mem_write_data);
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_logs();
    wa_addr.delete(); wa_data.delete(); da_nonce.delete();
    wb_addr.delete(); wb_data.delete();
  endtask

  task automatic wait_done_a(input int lim, output int rise);
    rise = -1;
    for (int i = 0; i < lim; i++) begin
      step();
      if (a_done) begin
        rise = cyc;
        break;
      end
    end
    check("a_done_within_budget", 32'(rise >= 0), 32'd1);
  endtask

  task automatic wait_done_b(input int lim);
    int rise;
    rise = -1;
    for (int i = 0; i < lim; i++) begin
      step();
      if (b_done) begin
        rise = cyc;
        break;
      end
    end
    check("b_done_within_budget", 32'(rise >= 0), 32'd1);
  endtask

  // Every offset 0..n-1 written exactly once with h0 = A5A50000 | nonce.
  task automatic check_run_a(input logic [15:0] base, input int n);
    check("a_write_count", wa_addr.size(), n);
    for (int off = 0; off < n; off++) begin
      int          hits;
      logic [31:0] d;
      logic [15:0] ea;
      hits = 0;
      d    = '0;
      ea   = base + 16'(off);
      for (int j = 0; j < wa_addr.size(); j++) begin
        if (wa_addr[j] == ea) begin
          hits++;
          d = wa_data[j];
        end
      end
      check("a_addr_hit_once", hits, 1);
      check("a_write_data", d, 32'hA5A50000 | off);
    end
  endtask

  logic [3:0]  exp_start [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
  logic [15:0] exp_wrap  [4] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};

  initial begin
    int acc, rise, waited;
    reset_n = 1'b0;
    a_start = 1'b0;
    b_start = 1'b0;
    a_output_addr = '0;
    b_output_addr = '0;
    hold = '0;
    step();
    step();

    check("rst_done", a_done, 1);
    check("rst_core_start", a_core_start, 0);
    check("rst_core_ack", a_core_ack, 0);
    check("rst_mem_we", a_mem_we, 0);
    check("rst_core_nonce", a_core_nonce, 0);
    check("rst_mem_addr", a_mem_addr, 0);
    check("rst_mem_data", a_mem_write_data, 0);
    check("rst_b_done", b_done, 1);
    reset_n = 1'b1;
    step();

    // Full run at 0x0100 with a stray start mid-run.
    clear_logs();
    a_output_addr = 16'h0100;
    a_start = 1'b1;
    step();
    acc = cyc;
    a_start = 1'b0;
    check("no_launch_at_accept", a_core_start, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("launch_onehot", a_core_start, exp_start[i]);
      check("launch_nonce", a_core_nonce, i);
      check("done_low_in_run", a_done, 0);
    end
    a_start = 1'b1;
    step();
    a_start = 1'b0;
    wait_done_a(400, rise);
    check("dispatch_count", da_nonce.size(), 16);
    for (int i = 0; i < da_nonce.size(); i++) check("dispatch_order", da_nonce[i], i);
    check_run_a(16'h0100, 16);
    check("done_two_after_last_write", rise, last_we_cyc + 2);
`ifdef NONCE_SCHED_CYCLES_EN
    check("cycle_count", a_cycle_count, rise - acc);
`endif

    // Address wrap on the 4-nonce instance.
    clear_logs();
    b_output_addr = 16'hFFFE;
    b_start = 1'b1;
    step();
    b_start = 1'b0;
    wait_done_b(200);
    check("wrap_write_count", wb_addr.size(), 4);
    for (int i = 0; i < 4 && i < wb_addr.size(); i++) begin
      check("wrap_addr", wb_addr[i], exp_wrap[i]);
      check("wrap_data", wb_data[i], 32'hA5A50000 | i);
    end

    // Round-robin: last grant core 1, then cores 1 and 3 finish together.
    clear_logs();
    a_output_addr = 16'h0200;
    hold = 8'h0F;
    a_start = 1'b1;
    step();
    a_start = 1'b0;
    repeat (20) step();
    check("held_no_writes", wa_addr.size(), 0);
    hold = 8'h0D;
    step();
    hold = 8'h0F;
    check("rr_prime_ack", a_core_ack, 4'b0010);
    check("rr_prime_addr", a_mem_addr, 16'h0201);
    repeat (20) step();
    check("rr_one_write", wa_addr.size(), 1);
    hold = 8'h05;
    step();
    check("rr_first_ack", a_core_ack, 4'b1000);
    check("rr_first_addr", a_mem_addr, 16'h0203);
    check("rr_first_data", a_mem_write_data, 32'hA5A50003);
    step();
    check("rr_second_ack", a_core_ack, 4'b0010);
    check("rr_second_addr", a_mem_addr, 16'h0204);
    check("rr_second_data", a_mem_write_data, 32'hA5A50004);
    hold = 8'h00;
    wait_done_a(400, rise);
    check_run_a(16'h0200, 16);

    // Reset after five writes, then a clean rerun.
    clear_logs();
    a_output_addr = 16'h0100;
    a_start = 1'b1;
    step();
    a_start = 1'b0;
    waited = 0;
    while (wa_addr.size() < 5 && waited < 200) begin
      step();
      waited++;
    end
    check("five_writes_seen", wa_addr.size(), 5);
    reset_n = 1'b0;
    #1;
    check("midrst_done", a_done, 1);
    check("midrst_mem_we", a_mem_we, 0);
    check("midrst_core_start", a_core_start, 0);
    check("midrst_core_ack", a_core_ack, 0);
    check("midrst_mem_addr", a_mem_addr, 0);
    step();
    reset_n = 1'b1;
    step();
    clear_logs();
    a_start = 1'b1;
    step();
    a_start = 1'b0;
    wait_done_a(400, rise);
    check_run_a(16'h0100, 16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
